pal_sweep_ctrl: RTL and testbench

Exhaustive self-test sequencer for a combinational PAL/PLA array.
- On `start`, drives every input vector 0..2^N_IN-1 into the array.
- Waits a programmable settle time per vector, then captures each output word into a truth-table register.
- On completion, compares the table against an expected table and reports pass/fail.
- Sits beside any PAL instance as its BIST/characterisation controller.

---
 rtl/pal_sweep_ctrl_pkg.sv | 14 +
 rtl/pal_sweep_ctrl_settle_timer.sv | 27 ++
 rtl/pal_sweep_ctrl.sv | 129 ++++++++++++
 tb/tb_pal_sweep_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/pal_sweep_ctrl_pkg.sv
// Shared definitions for the PAL sweep controller: FSM encodings and table sizing.
package pal_sweep_ctrl_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_APPLY  = 2'd1;
    localparam logic [1:0] ST_SAMPLE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    // Width of a packed truth table: one N_OUT-bit word per input vector.
    function automatic int table_width(input int n_in, input int n_out);
        return n_out * (1 << n_in);
    endfunction

endpackage

// File: rtl/pal_sweep_ctrl_settle_timer.sv
// pal_settle_timer: loadable down-counter with a zero flag, paces the per-vector settle wait.
module pal_settle_timer #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (dec && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/pal_sweep_ctrl.sv
// Exhaustive PAL/PLA self-test sequencer: sweeps all input vectors, captures a truth table, compares it.
// Optional first-failure reporting (fail_idx/fail_any) is enabled by defining PAL_SWEEP_FAIL_IDX_EN.
//
// state  | meaning
// IDLE   | waiting for start
// APPLY  | vector driven on pal_in, waiting SETTLE cycles
// SAMPLE | capture pal_out into the table, advance or finish
// DONE   | compare captured table against exp_table, pulse done
module pal_sweep_ctrl
    import pal_sweep_ctrl_pkg::*;
#(
    parameter int N_IN   = 3,
    parameter int N_OUT  = 3,
    parameter int SETTLE = 1
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 start,
    input  logic                                 abort,
    output logic [N_IN-1:0]                      pal_in,
    input  logic [N_OUT-1:0]                     pal_out,
    input  logic [table_width(N_IN, N_OUT)-1:0]  exp_table,
    output logic [table_width(N_IN, N_OUT)-1:0]  table_q,
`ifdef PAL_SWEEP_FAIL_IDX_EN
    output logic [N_IN-1:0]                      fail_idx,
    output logic                                 fail_any,
`endif
    output logic                                 busy,
    output logic                                 done,
    output logic                                 pass
);

    localparam int TW = table_width(N_IN, N_OUT);
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0]   SETTLE_M1 = CW'(SETTLE - 1);
    localparam logic [N_IN-1:0] LAST_VEC  = '1;

    logic [1:0] state_q;
    logic [1:0] state_d;
    logic       accept;
    logic       last_vec;
    logic       timer_load;
    logic       timer_zero;
    logic [N_OUT-1:0] exp_word;

    assign accept   = (state_q == ST_IDLE) && start && !abort;
    assign last_vec = (pal_in == LAST_VEC);
    assign exp_word = exp_table[int'(pal_in) * N_OUT +: N_OUT];

    assign timer_load = accept || ((state_q == ST_SAMPLE) && !abort && !last_vec);

    pal_settle_timer #(.W(CW)) u_settle_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load),
        .load_val (SETTLE_M1),
        .dec      (state_q == ST_APPLY),
        .zero     (timer_zero)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (accept) state_d = ST_APPLY;
            ST_APPLY: begin
                if (abort)           state_d = ST_IDLE;
                else if (timer_zero) state_d = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                if (abort)         state_d = ST_IDLE;
                else if (last_vec) state_d = ST_DONE;
                else               state_d = ST_APPLY;
            end
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pal_in  <= '0;
            table_q <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            pass    <= 1'b0;
        end else begin
            state_q <= state_d;
            done    <= (state_q == ST_DONE);
            if (accept) begin
                pal_in <= '0;
                busy   <= 1'b1;
                pass   <= 1'b0;
            end
            // A sample in progress is still captured even if abort arrives with it.
            if (state_q == ST_SAMPLE) begin
                table_q[int'(pal_in) * N_OUT +: N_OUT] <= pal_out;
                if (!abort && !last_vec) pal_in <= pal_in + 1'b1;
            end
            if (abort && ((state_q == ST_APPLY) || (state_q == ST_SAMPLE))) begin
                busy <= 1'b0;
                pass <= 1'b0;
            end
            if (state_q == ST_DONE) begin
                busy <= 1'b0;
                pass <= (table_q == exp_table);
            end
        end
    end

`ifdef PAL_SWEEP_FAIL_IDX_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fail_idx <= '0;
            fail_any <= 1'b0;
        end else if (accept) begin
            fail_idx <= '0;
            fail_any <= 1'b0;
        end else if ((state_q == ST_SAMPLE) && (pal_out != exp_word) && !fail_any) begin
            fail_idx <= pal_in;
            fail_any <= 1'b1;
        end
    end
`else
    logic unused_exp_word;
    assign unused_exp_word = ^exp_word;
`endif

endmodule

// File: tb/tb_pal_sweep_ctrl.sv
// Directed bench for pal_sweep_ctrl driving the reference PAL x=b, y=a'b+a'c'+ab'c, z=ab+a'b'c.
module tb_pal_sweep_ctrl;

    localparam int N_IN  = 3;
    localparam int N_OUT = 3;
    localparam int TW    = 24;
    localparam logic [TW-1:0] GOOD_TAB = 24'hB50D8A;

    logic clk = 1'b0;
    logic rst_n, start, start3, abort;
    logic [N_IN-1:0]  pal_in, pal_in3;
    logic [N_OUT-1:0] pal_out, pal_out3;
    logic [TW-1:0]    exp_table, table_q, table_q3;
    logic busy, done, pass, busy3, done3, pass3;
`ifdef PAL_SWEEP_FAIL_IDX_EN
    logic [N_IN-1:0] fail_idx, fail_idx3;
    logic fail_any, fail_any3;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    function automatic logic [2:0] pal_f(input logic [2:0] v);
        logic a, b, c;
        {a, b, c} = v;
        return {b, (~a & b) | (~a & ~c) | (a & ~b & c), (a & b) | (~a & ~b & c)};
    endfunction

    assign pal_out  = pal_f(pal_in);
    assign pal_out3 = pal_f(pal_in3);

    pal_sweep_ctrl #(.N_IN(N_IN), .N_OUT(N_OUT), .SETTLE(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .pal_in(pal_in), .pal_out(pal_out), .exp_table(exp_table), .table_q(table_q),
`ifdef PAL_SWEEP_FAIL_IDX_EN
        .fail_idx(fail_idx), .fail_any(fail_any),
`endif
        .busy(busy), .done(done), .pass(pass)
    );

    pal_sweep_ctrl #(.N_IN(N_IN), .N_OUT(N_OUT), .SETTLE(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .abort(1'b0),
        .pal_in(pal_in3), .pal_out(pal_out3), .exp_table(exp_table), .table_q(table_q3),
`ifdef PAL_SWEEP_FAIL_IDX_EN
        .fail_idx(fail_idx3), .fail_any(fail_any3),
`endif
        .busy(busy3), .done(done3), .pass(pass3)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, expv, $time);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    // Start is raised in cycle 0; returns in cycle 18 (IDLE) after checking the whole sweep.
    task automatic sweep(input logic [TW-1:0] exp_t, input logic exp_pass);
        exp_table = exp_t;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 18; c++) begin
            chk("busy", {31'd0, busy}, {31'd0, c <= 17});
            chk("done", {31'd0, done}, {31'd0, c == 18});
            if (c <= 16) chk("pal_in", {29'd0, pal_in}, 32'((c - 1) / 2));
            if (c == 1) chk("pass_cleared", {31'd0, pass}, 32'd0);
            if (c < 18) step();
        end
        chk("pass", {31'd0, pass}, {31'd0, exp_pass});
        chk("table_q", {8'd0, table_q}, {8'd0, GOOD_TAB});
    endtask

    initial begin
        rst_n = 1'b1; start = 1'b0; start3 = 1'b0; abort = 1'b0; exp_table = GOOD_TAB;

        // reset state
        do_reset();
        chk("rst_pal_in", {29'd0, pal_in}, 32'd0);
        chk("rst_table", {8'd0, table_q}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_pass", {31'd0, pass}, 32'd0);

        // abort at cycle 7 from a cleared table: entries 0..2 captured, vector 3 still applied
        start = 1'b1; step(); start = 1'b0;
        for (int c = 1; c < 7; c++) step();
        abort = 1'b1; step(); abort = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_partial_table", {8'd0, table_q}, 32'h0000018A);
        chk("abort_pal_in_hold", {29'd0, pal_in}, 32'd3);
        for (int c = 0; c < 12; c++) begin
            chk("abort_no_done", {31'd0, done}, 32'd0);
            step();
        end
        chk("abort_pass", {31'd0, pass}, 32'd0);

        // nominal sweep
        sweep(GOOD_TAB, 1'b1);
        step();
        chk("done_one_cycle", {31'd0, done}, 32'd0);
        chk("pass_held", {31'd0, pass}, 32'd1);

        // mismatch on entry 0, followed back-to-back by a nominal sweep
        sweep(24'hB50D8B, 1'b0);
`ifdef PAL_SWEEP_FAIL_IDX_EN
        chk("fail_idx", {29'd0, fail_idx}, 32'd0);
        chk("fail_any", {31'd0, fail_any}, 32'd1);
`endif
        sweep(GOOD_TAB, 1'b1);
`ifdef PAL_SWEEP_FAIL_IDX_EN
        chk("fail_any_clear", {31'd0, fail_any}, 32'd0);
`endif

        // abort at cycle 7 after a full sweep: table contents stay intact
        step();
        start = 1'b1; step(); start = 1'b0;
        for (int c = 1; c < 7; c++) step();
        abort = 1'b1; step(); abort = 1'b0;
        chk("abort2_busy", {31'd0, busy}, 32'd0);
        chk("abort2_table", {8'd0, table_q}, {8'd0, GOOD_TAB});
        for (int c = 0; c < 12; c++) begin
            chk("abort2_no_done", {31'd0, done}, 32'd0);
            step();
        end

        // start and abort together in IDLE
        start = 1'b1; abort = 1'b1; step(); start = 1'b0; abort = 1'b0;
        for (int c = 0; c < 4; c++) begin
            chk("sa_busy", {31'd0, busy}, 32'd0);
            chk("sa_pal_in", {29'd0, pal_in}, 32'd3);
            step();
        end

        // start re-asserted at cycle 5 while busy is ignored
        start = 1'b1; step(); start = 1'b0;
        for (int c = 1; c <= 24; c++) begin
            chk("sb_busy", {31'd0, busy}, {31'd0, c <= 17});
            chk("sb_done", {31'd0, done}, {31'd0, c == 18});
            if (c == 5) start = 1'b1;
            if (c == 6) start = 1'b0;
            step();
        end
        chk("sb_pass", {31'd0, pass}, 32'd1);

        // reset at cycle 9, then a clean sweep
        start = 1'b1; step(); start = 1'b0;
        for (int c = 1; c < 9; c++) step();
        rst_n = 1'b0; step(); rst_n = 1'b1;
        chk("mrst_pal_in", {29'd0, pal_in}, 32'd0);
        chk("mrst_table", {8'd0, table_q}, 32'd0);
        chk("mrst_busy", {31'd0, busy}, 32'd0);
        chk("mrst_done", {31'd0, done}, 32'd0);
        chk("mrst_pass", {31'd0, pass}, 32'd0);
        step();
        sweep(GOOD_TAB, 1'b1);
        step();

        // SETTLE=3 instance: four cycles per vector, done at cycle 34
        start3 = 1'b1; step(); start3 = 1'b0;
        for (int c = 1; c <= 36; c++) begin
            chk("s3_busy", {31'd0, busy3}, {31'd0, c <= 33});
            chk("s3_done", {31'd0, done3}, {31'd0, c == 34});
            if (c <= 32) chk("s3_pal_in", {29'd0, pal_in3}, 32'((c - 1) / 4));
            if (c == 34) begin
                chk("s3_pass", {31'd0, pass3}, 32'd1);
                chk("s3_table", {8'd0, table_q3}, {8'd0, GOOD_TAB});
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
